// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state encoding and default widths for the ALU op sequencer.
package alu_seq_pkg;

  localparam int unsigned N_DEF = 32;
  localparam int unsigned L_DEF = 4;

  localparam logic [L_DEF-1:0] ALU_ADD     = 4'b0001;
  localparam logic [L_DEF-1:0] ALU_ADD_ALT = 4'b0011;
  localparam logic [L_DEF-1:0] ALU_SUB     = 4'b0010;
  localparam logic [L_DEF-1:0] ALU_SUB_ALT = 4'b0100;
  localparam logic [L_DEF-1:0] ALU_MUL     = 4'b0101;
  localparam logic [L_DEF-1:0] ALU_DIV     = 4'b0110;
  localparam logic [L_DEF-1:0] ALU_OR      = 4'b0111;
  localparam logic [L_DEF-1:0] ALU_AND     = 4'b1000;
  localparam logic [L_DEF-1:0] ALU_XOR     = 4'b1001;
  localparam logic [L_DEF-1:0] ALU_SLL     = 4'b1010;
  localparam logic [L_DEF-1:0] ALU_SRL     = 4'b1011;
  localparam logic [L_DEF-1:0] ALU_SLT     = 4'b1100;
  localparam logic [L_DEF-1:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_SINGLE  = 2'd0,
    KIND_MUL     = 2'd1,
    KIND_DIV     = 2'd2,
    KIND_ILLEGAL = 2'd3
  } op_kind_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative datapath: LSB-first shift-add multiply and restoring divide, one bit per step.
module alu_iter_muldiv
  import alu_seq_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] result_c,
  output logic         done_early
);

  // mplier doubles as the quotient shift register; mcand doubles as the divisor.
  logic [N-1:0] acc;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic [N-1:0] rem;
  logic [N:0]   rem_sh;
  logic [N:0]   diff;
  logic [N-1:0] acc_add;
  logic [N-1:0] quo_step;

  // Value each register takes on this step; result_c exposes the post-step answer.
  always_comb begin
    rem_sh   = {rem, mplier[N-1]};
    diff     = rem_sh - {1'b0, mcand};
    quo_step = {mplier[N-2:0], ~diff[N]};
    acc_add  = mplier[0] ? (acc + mcand) : acc;
    result_c = is_div ? quo_step : acc_add;
  end

  // done_early flags that the bit consumed by the next step is the last set multiplier bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      done_early <= 1'b0;
    end else if (load) begin
      acc        <= '0;
      rem        <= '0;
      mcand      <= is_div ? op_b : op_a;
      mplier     <= is_div ? op_a : op_b;
      done_early <= (op_b[N-1:1] == '0);
    end else if (step) begin
      if (is_div) begin
        rem    <= diff[N] ? rem_sh[N-1:0] : diff[N-1:0];
        mplier <= quo_step;
      end else begin
        acc        <= acc_add;
        mcand      <= mcand << 1;
        mplier     <= mplier >> 1;
        done_early <= (mplier[N-1:2] == '0);
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: single-cycle ops in one cycle, iterative mul/div with busy stall.
// Define ALU_SEQ_EARLY_OUT_EN to let MUL finish once the remaining multiplier bits are zero.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned L = L_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [L-1:0] alu_control,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned SHW = $clog2(N);

`ifdef ALU_SEQ_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  state_t       state;
  state_t       state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [N-1:0] res_n;
  logic         err_n;
  logic         accept_c;
  logic         load_c;
  logic         step_c;
  logic         is_div_c;
  logic [N-1:0] alu_c;
  op_kind_t     kind_c;
  logic [N-1:0] step_res_c;
  logic         done_early;

  alu_iter_muldiv #(.N(N)) u_muldiv (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .step       (step_c),
    .is_div     (is_div_c),
    .op_a       (op_a),
    .op_b       (op_b),
    .result_c   (step_res_c),
    .done_early (done_early)
  );

  // Single-cycle ALU and op classification.
  always_comb begin
    alu_c  = '0;
    kind_c = KIND_SINGLE;
    case (alu_control)
      L'(ALU_ADD), L'(ALU_ADD_ALT): alu_c = op_a + op_b;
      L'(ALU_SUB), L'(ALU_SUB_ALT): alu_c = op_a - op_b;
      L'(ALU_OR):  alu_c = op_a | op_b;
      L'(ALU_AND): alu_c = op_a & op_b;
      L'(ALU_XOR): alu_c = op_a ^ op_b;
      L'(ALU_SLL): alu_c = op_a << op_b[SHW-1:0];
      L'(ALU_SRL): alu_c = op_a >> op_b[SHW-1:0];
      L'(ALU_SLT): alu_c = {{(N-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      L'(ALU_MUL): kind_c = KIND_MUL;
      L'(ALU_DIV): kind_c = KIND_DIV;
      default:     kind_c = KIND_ILLEGAL;
    endcase
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    res_n    = result;
    err_n    = out_err;
    load_c   = 1'b0;
    step_c   = 1'b0;
    is_div_c = (state == DIV);
    accept_c = in_valid && in_ready;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept_c) begin
          cnt_n = '0;
          case (kind_c)
            KIND_SINGLE: begin
              state_n = DONE;
              res_n   = alu_c;
              err_n   = 1'b0;
            end
            KIND_MUL: begin
              if (EarlyOut && (op_b == '0)) begin
                state_n = DONE;
                res_n   = '0;
                err_n   = 1'b0;
              end else begin
                state_n = MUL;
                load_c  = 1'b1;
              end
            end
            KIND_DIV: begin
              if (op_b == '0) begin
                state_n = DONE;
                res_n   = '1;
                err_n   = 1'b1;
              end else begin
                state_n  = DIV;
                load_c   = 1'b1;
                is_div_c = 1'b1;
              end
            end
            default: begin
              state_n = DONE;
              res_n   = '0;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      MUL, DIV: begin
        step_c = 1'b1;
        cnt_n  = cnt + CW'(1);
        if ((cnt == CW'(N-1)) || ((state == MUL) && EarlyOut && done_early)) begin
          state_n = DONE;
          res_n   = step_res_c;
          err_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; handshake flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      result    <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      result    <= res_n;
      out_err   <= err_n;
      out_valid <= (state_n == DONE);
      in_ready  <= (state_n == IDLE) || (state_n == DONE);
      busy      <= (state_n == MUL) || (state_n == DIV);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table plus scoreboard of expected results.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic [31:0] result;
  logic        out_err;
  logic        busy;

  alu_op_sequencer #(.N(32), .L(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .result      (result),
    .out_err     (out_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          err;
    int          extra;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    bit          err;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Extra cycles beyond the single-cycle latency for a multiply by b.
  function automatic int mul_extra(input logic [31:0] b);
`ifdef ALU_SEQ_EARLY_OUT_EN
    int hb;
    hb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) hb = i;
    return hb + 1;
`else
    return 32;
`endif
  endfunction

  // Scoreboard: every out_valid pops one expected record.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("stray_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("out_err", 32'(out_err), 32'(e.err));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input bit err, input int extra);
    int n;
    in_valid    = 1'b1;
    alu_control = code;
    op_a        = a;
    op_b        = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back('{res, err, cyc + 1 + extra});
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    bit ready_seen;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs.push_back('{4'b0001, 32'd5,          32'd7,          32'd12,         1'b0, 0});
    vecs.push_back('{4'b0010, 32'd3,          32'd4,          32'hFFFF_FFFF,  1'b0, 0});
    vecs.push_back('{4'b0011, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0, 0});
    vecs.push_back('{4'b0100, 32'd10,         32'd3,          32'd7,          1'b0, 0});
    vecs.push_back('{4'b0111, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 0});
    vecs.push_back('{4'b1000, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1'b0, 0});
    vecs.push_back('{4'b1001, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0, 0});
    vecs.push_back('{4'b1010, 32'd1,          32'd33,         32'd2,          1'b0, 0});
    vecs.push_back('{4'b1011, 32'h8000_0000,  32'd31,         32'd1,          1'b0, 0});
    vecs.push_back('{4'b1100, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 0});
    vecs.push_back('{4'b1100, 32'd5,          32'hFFFF_FFFF,  32'd0,          1'b0, 0});
    vecs.push_back('{4'b1111, 32'd9,          32'd9,          32'd0,          1'b1, 0});
    vecs.push_back('{4'b0000, 32'd1,          32'd2,          32'd0,          1'b1, 0});
    vecs.push_back('{4'b0110, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 0});
    vecs.push_back('{4'b0110, 32'd100,        32'd7,          32'd14,         1'b0, 32});
    vecs.push_back('{4'b0110, 32'd3,          32'd10,         32'd0,          1'b0, 32});
    vecs.push_back('{4'b0110, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 32});
    vecs.push_back('{4'b0101, 32'h1234,       32'h10,         32'h1_2340,     1'b0, mul_extra(32'h10)});
    vecs.push_back('{4'b0101, 32'd7,          32'd0,          32'd0,          1'b0, mul_extra(32'd0)});
    vecs.push_back('{4'b0101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, mul_extra(32'hFFFF_FFFF)});
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom | 32'd1;
      if (i[0]) vecs.push_back('{4'b0110, ra, rb, ra / rb, 1'b0, 32});
      else      vecs.push_back('{4'b0101, ra, rb, ra * rb, 1'b0, mul_extra(rb)});
    end

    rst = 1'b1;
    in_valid = 1'b0;
    alu_control = 4'b0000;
    op_a = '0;
    op_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back.
    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, vecs[i].extra);
    drain();

    // Busy/in_ready window of a multiply.
    send(4'b0101, 32'h1234, 32'h10, 32'h1_2340, 1'b0, mul_extra(32'h10));
    busy_cnt = 0;
    ready_seen = 1'b0;
    while (busy && busy_cnt < 100) begin
      busy_cnt++;
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 32'(busy_cnt), 32'(mul_extra(32'h10)));
    chk("mul_ready_while_busy", 32'(ready_seen), 32'd0);
    drain();

    // Reset during a multiply abandons it.
    send(4'b0101, 32'd3, 32'hFFFF_0005, 32'd0, 1'b0, 32);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    repeat (40) @(negedge clk);

    // Reset and a request in the same cycle: request dropped.
    in_valid = 1'b1;
    alu_control = 4'b0001;
    op_a = 32'd1;
    op_b = 32'd1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_drop_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("rst_drop_out_valid2", 32'(out_valid), 32'd0);
    send(4'b0001, 32'd20, 32'd22, 32'd42, 1'b0, 0);
    drain();

    // Input churn during a divide must not be accepted nor disturb the quotient.
    send(4'b0110, 32'd100, 32'd7, 32'd14, 1'b0, 32);
    for (int i = 0; i < 20; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      alu_control = 4'b0001;
      op_a        = $urandom;
      op_b        = $urandom;
      chk("div_no_accept", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
